serial_adder: RTL and testbench
===============================

// Module: serial_adder
// PURPOSE
//  Bit-serial WIDTH-bit adder. One 1-bit full_adder cell plus a carry flip-flop
//  computes A+B+cin LSB-first, one bit per clock.
//  It is the sequential stage that feeds the full-adder cell, trading area for latency.
//  Operands are loaded in parallel. The result is returned in parallel with a done pulse.
// PARAMETERS
//  WIDTH  8  operand/result width in bits; legal range WIDTH >= 2
// PORTS
//  clk    in   1      single clock; all state updates on rising edge
//  rst_n  in   1      synchronous reset, active-low
//  start  in   1      request; sampled only in IDLE
//  a_in   in   WIDTH  operand A, captured on accepted start
//  b_in   in   WIDTH  operand B, captured on accepted start
//  cin    in   1      carry-in, captured on accepted start
//  busy   out  1      high while in SHIFT or DONE
//  done   out  1      one-cycle pulse; sum/cout valid this cycle
//  sum    out  WIDTH  result; held from done until next accepted start
//  cout   out  1      carry-out of bit WIDTH-1; held like sum
//  ovf    out  1      signed overflow (present only with SERIAL_ADDER_OVF_EN)
// BEHAVIOUR
//  - Reset (rst_n=0 at edge): state=IDLE. busy, done, sum, cout and ovf are 0.
//    Shift regs, carry FF and bit counter are 0.
//  - Reset mid-operation aborts the add. No done is produced.
//  - FSM states: IDLE, SHIFT, DONE.
//  - IDLE:
//    - On start=1: load a_sr<=a_in, b_sr<=b_in, carry<=cin, cnt<=0; go to SHIFT.
//    - On start=0: stay in IDLE.
//  - SHIFT, each edge:
//    - {c,s} = FA(a_sr[0], b_sr[0], carry).
//    - s_sr <= {s, s_sr[WIDTH-1:1]}; a_sr, b_sr shift right; carry <= c; cnt++.
//  - SHIFT exit: at the edge where cnt==WIDTH-1, go to DONE.
//    - Same edge: sum <= {s, s_sr[WIDTH-1:1]}, cout <= c.
//  - DONE: done=1 for exactly one cycle, then IDLE. start seen in DONE is ignored.
//  - busy = (state != IDLE). start while busy is ignored; no queueing.
//  - Operands are not re-sampled during SHIFT.
//  - Latency: start sampled at edge E0 -> done high in the cycle after edge E0+WIDTH.
//    That is WIDTH+1 cycles from start to done.
//  - Throughput: one add per WIDTH+2 cycles. The earliest next start is the first IDLE cycle.
//  - Arithmetic is unsigned modulo 2^WIDTH; cout is the true bit WIDTH.
//  - cnt width is $clog2(WIDTH); no wrap issue because the exit is at WIDTH-1.
//  - Outputs are registered; no combinational path from inputs to outputs.
// CONFIGURATION
//  - SERIAL_ADDER_OVF_EN defined:
//    - Port ovf exists. Register the carry into the MSB (carry FF value at cnt==WIDTH-1).
//    - ovf <= c_into_msb ^ cout, updated with sum and held likewise; reset 0.
//  - Not defined: no ovf port and no extra register. The rest of the behaviour is identical.
// TESTING (WIDTH=8 unless noted)
//  1. a=8'h35, b=8'h4A, cin=0, start 1 cycle
//     -> busy next cycle; done 9 cycles after the start edge; sum=8'h7F, cout=0.
//  2. a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1.
//     a=8'h00, b=8'h00, cin=1 -> sum=8'h01, cout=0.
//  3. With SERIAL_ADDER_OVF_EN: a=8'h7F, b=8'h01 -> sum=8'h80, cout=0, ovf=1.
//     a=8'hFF, b=8'hFF -> sum=8'hFE, cout=1, ovf=0.
//  4. Start a=8'h10, b=8'h20, then raise start with a=8'hAA mid-SHIFT
//     -> ignored; sum=8'h30. sum is held after done until the next start.
//  5. rst_n=0 for 1 cycle at cnt=3
//     -> next cycle IDLE, busy=0, sum=0, no done.
//     A new start then completes normally.
//  6. start held high continuously with new operands
//     -> adds complete every 10 cycles. done pulses are exactly 1 cycle wide.
//     WIDTH=2: 2'b11+2'b01 -> sum=2'b00, cout=1.

Source files
------------

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder cell plus a carry flop, LSB first.
// Define SERIAL_ADDER_OVF_EN to add the registered signed-overflow output ovf.
module serial_adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sr, b_sr;
  logic [WIDTH-2:0] s_sr;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             fa_s, fa_c, last_bit;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Full-adder cell and next-state logic
  always_comb begin
    state_nxt = state;
    fa_s      = a_sr[0] ^ b_sr[0] ^ carry;
    fa_c      = (a_sr[0] & b_sr[0]) | (carry & (a_sr[0] ^ b_sr[0]));
    last_bit  = (cnt == CW'(WIDTH - 1));
    case (state)
      IDLE:    if (start) state_nxt = SHIFT;
      SHIFT:   if (last_bit) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_sr  <= '0;
      b_sr  <= '0;
      s_sr  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf   <= 1'b0;
`endif
    end else begin
      busy <= (state_nxt != IDLE);
      done <= (state_nxt == DONE);
      case (state)
        IDLE: begin
          if (start) begin
            a_sr  <= a_in;
            b_sr  <= b_in;
            carry <= cin;
            cnt   <= '0;
          end
        end
        SHIFT: begin
          // s_sr keeps the WIDTH-1 most recent sum bits, newest at the top
          s_sr  <= (WIDTH-1)'({fa_s, s_sr} >> 1);
          a_sr  <= a_sr >> 1;
          b_sr  <= b_sr >> 1;
          carry <= fa_c;
          cnt   <= cnt + CW'(1);
          if (last_bit) begin
            sum  <= {fa_s, s_sr};
            cout <= fa_c;
`ifdef SERIAL_ADDER_OVF_EN
            ovf  <= carry ^ fa_c;
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: cycle-level behavioural model plus directed
// literal checks, and a second WIDTH=2 instance.
module tb_serial_adder;
  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a, b;
  logic         cin;
  logic         busy, done, cout;
  logic [W-1:0] sum;
`ifdef SERIAL_ADDER_OVF_EN
  logic         ovf, ovf2;
`endif

  logic         start2, cin2, busy2, done2, cout2;
  logic [1:0]   a2, b2, sum2;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  bit chk_en  = 1'b0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a_in(a), .b_in(b), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .cout(cout)
`ifdef SERIAL_ADDER_OVF_EN
    , .ovf(ovf)
`endif
  );

  serial_adder #(.WIDTH(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .a_in(a2), .b_in(b2), .cin(cin2),
    .busy(busy2), .done(done2), .sum(sum2), .cout(cout2)
`ifdef SERIAL_ADDER_OVF_EN
    , .ovf(ovf2)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Behavioural model: an accepted start keeps the block busy for W+1 cycles,
  // the last of which is the done cycle carrying a+b+cin.
  int           m_left = 0;
  logic         m_busy = 0, m_done = 0, m_cout = 0, m_ovf = 0;
  logic [W-1:0] m_sum = '0;
  logic         p_cout, p_ovf;
  logic [W-1:0] p_sum;

  function automatic logic signed_ovf(input logic [W-1:0] x, input logic [W-1:0] y,
                                      input logic c);
    int s;
    s = int'($signed(x)) + int'($signed(y)) + int'(c);
    return (s > 127) || (s < -128);
  endfunction

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst_n) begin
      m_left <= 0; m_busy <= 1'b0; m_done <= 1'b0;
      m_sum  <= '0; m_cout <= 1'b0; m_ovf <= 1'b0;
    end else if (m_left == 0) begin
      m_done <= 1'b0;
      if (start) begin
        m_left          <= W + 1;
        m_busy          <= 1'b1;
        {p_cout, p_sum} <= 9'(a) + 9'(b) + 9'(cin);
        p_ovf           <= signed_ovf(a, b, cin);
      end else begin
        m_busy <= 1'b0;
      end
    end else begin
      m_left <= m_left - 1;
      m_busy <= (m_left > 1);
      m_done <= (m_left == 2);
      if (m_left == 2) begin
        m_sum  <= p_sum;
        m_cout <= p_cout;
        m_ovf  <= p_ovf;
      end
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", 32'(busy), 32'(m_busy));
      chk("done", 32'(done), 32'(m_done));
      chk("sum",  32'(sum),  32'(m_sum));
      chk("cout", 32'(cout), 32'(m_cout));
`ifdef SERIAL_ADDER_OVF_EN
      chk("ovf",  32'(ovf),  32'(m_ovf));
`endif
    end
  end

  // Pulse start for one cycle, wait for done and pin the literal result and latency
  task automatic do_add(input string name, input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic c, input logic [W-1:0] esum, input logic ecout);
    int k;
    k = 0;
    while (busy && k < 30) begin @(negedge clk); k++; end
    a = x; b = y; cin = c; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({name, "_busy_next"}, 32'(busy), 32'd1);
    k = 1;
    while (!done && k < 30) begin @(negedge clk); k++; end
    chk({name, "_latency"}, 32'(k), 32'(W + 1));
    chk({name, "_sum"}, 32'(sum), 32'(esum));
    chk({name, "_cout"}, 32'(cout), 32'(ecout));
  endtask

  initial begin
    int dcnt, last_d, k;
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    start2 = 1'b0; a2 = '0; b2 = '0; cin2 = 1'b0;
    @(posedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_sum", 32'(sum), 32'd0);
    chk("reset_done", 32'(done), 32'd0);

    do_add("t1", 8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0);
    do_add("t2a", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
    do_add("t2b", 8'h00, 8'h00, 1'b1, 8'h01, 1'b0);
`ifdef SERIAL_ADDER_OVF_EN
    do_add("t3a", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0);
    chk("t3a_ovf", 32'(ovf), 32'd1);
    do_add("t3b", 8'hFF, 8'hFF, 1'b0, 8'hFE, 1'b1);
    chk("t3b_ovf", 32'(ovf), 32'd0);
`endif

    // Start raised mid-SHIFT must be ignored; result held afterwards
    @(negedge clk); @(negedge clk);
    a = 8'h10; b = 8'h20; cin = 1'b0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);
    a = 8'hAA; start = 1'b1;
    repeat (2) @(negedge clk);
    start = 1'b0;
    k = 0;
    while (!done && k < 30) begin @(negedge clk); k++; end
    chk("t4_sum", 32'(sum), 32'h30);
    repeat (4) @(negedge clk);
    chk("t4_hold", 32'(sum), 32'h30);

    // Reset at cnt==3 aborts without done
    a = 8'h11; b = 8'h22; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_sum", 32'(sum), 32'd0);
    dcnt = 0;
    repeat (12) begin @(negedge clk); if (done) dcnt++; end
    chk("t5_no_done", 32'(dcnt), 32'd0);
    do_add("t5_after", 8'h12, 8'h34, 1'b1, 8'h47, 1'b0);

    // Start held high: one add every W+2 cycles, single-cycle done pulses
    while (busy) @(negedge clk);
    start = 1'b1; dcnt = 0; last_d = -1;
    for (int i = 0; i < 45; i++) begin
      a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
      @(negedge clk);
      if (done) begin
        if (last_d >= 0) chk("t6_period", 32'(cyc - last_d), 32'(W + 2));
        last_d = cyc; dcnt++;
      end
    end
    start = 1'b0;
    chk("t6_count", 32'(dcnt), 32'd4);

    // WIDTH=2 instance
    a2 = 2'b11; b2 = 2'b01; cin2 = 1'b0; start2 = 1'b1;
    @(negedge clk); start2 = 1'b0;
    k = 1;
    while (!done2 && k < 20) begin @(negedge clk); k++; end
    chk("w2_latency", 32'(k), 32'd3);
    chk("w2_sum", 32'(sum2), 32'd0);
    chk("w2_cout", 32'(cout2), 32'd1);

    // Randomized traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
      start = ($urandom_range(0, 2) == 0);
      rst_n = ($urandom_range(0, 199) != 0);
      @(negedge clk);
    end
    rst_n = 1'b1; start = 1'b0;
    repeat (12) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
